// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write arbiter: FSM states, word width,
// the CCD slave address and field offsets inside a {slave, sub, data16} word.
package i2c_pkg;

    localparam int unsigned I2C_WORD_W     = 32;
    localparam logic [7:0]  CCD_SLAVE_ADDR = 8'hBA;

    localparam int unsigned SLAVE_LSB = 24;
    localparam int unsigned SUB_LSB   = 16;
    localparam int unsigned DATA_LSB  = 0;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_END,
        RETRY,
        DONE
    } i2c_state_e;

endpackage

// File: rtl/i2c_tick_gen.sv
// I2C control-clock divider: each half-period lasts DIV+1 system clocks, and
// o_tick_fall flags the system cycle in which the control clock will fall.
module i2c_tick_gen #(
    parameter int unsigned DIV = 2500
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_ctrl_clk,
    output logic o_tick_fall
);

    localparam int unsigned CW = (DIV < 2) ? 1 : $clog2(DIV + 1);

    logic [CW-1:0] r_div;
    logic          r_clk;
    logic          w_wrap;

    assign w_wrap = (r_div == CW'(DIV));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div <= '0;
            r_clk <= 1'b0;
        end else if (w_wrap) begin
            r_div <= '0;
            r_clk <= ~r_clk;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign o_ctrl_clk  = r_clk;
    assign o_tick_fall = w_wrap & r_clk;

endmodule

// File: rtl/i2c_write_arbiter.sv
// Round-robin arbiter sharing one i2c_controller between N_REQ register writers,
// with NACK retry and END timeout; the FSM only moves on control-clock falls.
module i2c_write_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_Freq      = 50000000,
    parameter int unsigned I2C_Freq      = 20000,
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned MAX_RETRY     = 2,
    parameter int unsigned TIMEOUT_TICKS = 200
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic [N_REQ-1:0]            iREQ,
    input  logic [I2C_WORD_W*N_REQ-1:0] iREQ_DATA,
    output logic [N_REQ-1:0]            oGRANT,
    output logic [N_REQ-1:0]            oDONE,
    output logic                        oERR,
    output logic                        oBUSY,
    output logic                        oI2C_CTRL_CLK,
    output logic                        oI2C_GO,
    output logic [I2C_WORD_W-1:0]       oI2C_DATA,
    input  logic                        iI2C_END,
    input  logic                        iI2C_ACK
);

    localparam int unsigned DIV = CLK_Freq / I2C_Freq;
    localparam int unsigned PW  = (N_REQ < 2) ? 1 : $clog2(N_REQ);
    localparam int unsigned RW  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int unsigned TW  = (TIMEOUT_TICKS < 1) ? 1 : $clog2(TIMEOUT_TICKS + 1);

    i2c_state_e              r_state, w_state_n;
    logic [PW-1:0]           r_ptr, w_ptr_n;
    logic [PW-1:0]           r_owner, w_owner_n;
    logic [RW-1:0]           r_retry, w_retry_n;
    logic [TW-1:0]           r_tcnt, w_tcnt_n, w_tcnt_inc;
    logic                    r_err, w_err_n;
    logic [I2C_WORD_W-1:0]   r_data, w_data_n;
    logic                    r_go, w_go_n;
    logic [N_REQ-1:0]        r_grant, w_grant_n;
    logic [N_REQ-1:0]        r_done, w_done_n;
    logic                    r_oerr, w_oerr_n;
    logic                    r_busy, w_busy_n;

    logic                    w_tick;
    logic                    w_found;
    logic [PW-1:0]           w_win;
    logic [PW-1:0]           w_win_next;
    logic [I2C_WORD_W-1:0]   w_win_data;

    i2c_tick_gen #(.DIV(DIV)) u_tick (
        .i_clk      (iCLK),
        .i_rst      (iRST),
        .o_ctrl_clk (oI2C_CTRL_CLK),
        .o_tick_fall(w_tick)
    );

    // Search upward from the pointer with wrap; the first hit wins.
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_win_next = '0;
        w_win_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            int unsigned idx;
            idx = k + 32'(r_ptr);
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!w_found && iREQ[idx]) begin
                w_found    = 1'b1;
                w_win      = PW'(idx);
                w_win_next = PW'((idx + 1 == N_REQ) ? 0 : idx + 1);
                w_win_data = iREQ_DATA[idx*I2C_WORD_W +: I2C_WORD_W];
            end
        end
    end

    assign w_tcnt_inc = r_tcnt + 1'b1;

    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_owner_n = r_owner;
        w_retry_n = r_retry;
        w_tcnt_n  = r_tcnt;
        w_err_n   = r_err;
        w_data_n  = r_data;
        w_go_n    = r_go;
        w_grant_n = '0;
        w_done_n  = '0;
        w_oerr_n  = 1'b0;
        w_busy_n  = r_busy;
        if (w_tick) begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        w_data_n         = w_win_data;
                        w_grant_n[w_win] = 1'b1;
                        w_busy_n         = 1'b1;
                        w_retry_n        = '0;
                        w_owner_n        = w_win;
                        w_ptr_n          = w_win_next;
                        w_state_n        = ISSUE;
                    end
                end
                ISSUE: begin
                    w_go_n    = 1'b1;
                    w_tcnt_n  = '0;
                    w_state_n = WAIT_END;
                end
                WAIT_END: begin
                    w_tcnt_n = w_tcnt_inc;
                    // Timeout wins even if END shows up on the same tick.
                    if (w_tcnt_inc == TW'(TIMEOUT_TICKS)) begin
                        w_go_n    = 1'b0;
                        w_err_n   = 1'b1;
                        w_state_n = DONE;
                    end else if (iI2C_END) begin
                        w_go_n = 1'b0;
                        if (!iI2C_ACK) begin
                            w_err_n   = 1'b0;
                            w_state_n = DONE;
                        end else if (r_retry < RW'(MAX_RETRY)) begin
                            w_retry_n = r_retry + 1'b1;
                            w_state_n = RETRY;
                        end else begin
                            w_err_n   = 1'b1;
                            w_state_n = DONE;
                        end
                    end
                end
                RETRY: begin
                    w_state_n = ISSUE;
                end
                DONE: begin
                    w_done_n[r_owner] = 1'b1;
                    w_oerr_n          = r_err;
                    w_busy_n          = 1'b0;
                    w_state_n         = IDLE;
                end
                default: begin
                    w_state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_retry <= '0;
            r_tcnt  <= '0;
            r_err   <= 1'b0;
            r_data  <= '0;
            r_go    <= 1'b0;
            r_grant <= '0;
            r_done  <= '0;
            r_oerr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_ptr   <= w_ptr_n;
            r_owner <= w_owner_n;
            r_retry <= w_retry_n;
            r_tcnt  <= w_tcnt_n;
            r_err   <= w_err_n;
            r_data  <= w_data_n;
            r_go    <= w_go_n;
            r_grant <= w_grant_n;
            r_done  <= w_done_n;
            r_oerr  <= w_oerr_n;
            r_busy  <= w_busy_n;
        end
    end

    assign oGRANT    = r_grant;
    assign oDONE     = r_done;
    assign oERR      = r_oerr;
    assign oBUSY     = r_busy;
    assign oI2C_GO   = r_go;
    assign oI2C_DATA = r_data;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Directed bench for i2c_write_arbiter (DIV=11, TIMEOUT_TICKS=5) with a
// behavioural i2c_controller that raises END after 3 control-clock rises.
module tb_i2c_write_arbiter;
    import i2c_pkg::*;

    logic         iCLK = 1'b0;
    logic         iRST = 1'b1;
    logic [3:0]   iREQ = '0;
    logic [127:0] iREQ_DATA;
    logic [3:0]   oGRANT, oDONE;
    logic         oERR, oBUSY, oI2C_CTRL_CLK, oI2C_GO;
    logic [31:0]  oI2C_DATA;
    logic         iI2C_END = 1'b0;
    logic         iI2C_ACK = 1'b0;

    localparam logic [31:0] D0 = 32'hBA20C000;
    localparam logic [31:0] D1 = 32'hBA21C001;
    localparam logic [31:0] D2 = 32'hBA22C002;
    localparam logic [31:0] D3 = 32'hBA23C003;

    assign iREQ_DATA = {D3, D2, D1, D0};

    i2c_write_arbiter #(
        .CLK_Freq(110), .I2C_Freq(10), .N_REQ(4), .MAX_RETRY(2), .TIMEOUT_TICKS(5)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iREQ(iREQ), .iREQ_DATA(iREQ_DATA),
        .oGRANT(oGRANT), .oDONE(oDONE), .oERR(oERR), .oBUSY(oBUSY),
        .oI2C_CTRL_CLK(oI2C_CTRL_CLK), .oI2C_GO(oI2C_GO), .oI2C_DATA(oI2C_DATA),
        .iI2C_END(iI2C_END), .iI2C_ACK(iI2C_ACK)
    );

    always #5 iCLK = ~iCLK;

    // Controller model: END (with ACK=m_nack) on the 3rd control-clock rise while GO.
    logic m_nack = 1'b0;
    logic m_never = 1'b0;
    logic m_prev_cc = 1'b0;
    int   m_cnt = 0;
    always @(posedge iCLK) begin
        m_prev_cc <= oI2C_CTRL_CLK;
        if (!oI2C_GO) begin
            m_cnt    <= 0;
            iI2C_END <= 1'b0;
            iI2C_ACK <= 1'b0;
        end else if (oI2C_CTRL_CLK && !m_prev_cc && !m_never && !iI2C_END) begin
            if (m_cnt == 2) begin
                iI2C_END <= 1'b1;
                iI2C_ACK <= m_nack;
            end
            m_cnt <= m_cnt + 1;
        end
    end

    int   go_rises = 0, done_pulses = 0, viol = 0, stray_err = 0;
    logic go_q = 1'b0;
    always @(negedge iCLK) begin
        if (oI2C_GO === 1'b1 && go_q === 1'b0) go_rises++;
        go_q = oI2C_GO;
        if (oDONE != 0) done_pulses++;
        if (oI2C_GO === 1'b1 && (oBUSY !== 1'b1 || oDONE != 0)) viol++;
        if (oERR === 1'b1 && oDONE == 0) stray_err++;
    end

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no event expected one within 3000 cycles", name);
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        iREQ = '0;
        repeat (3) step();
        check("reset_outputs",
              {oGRANT, oDONE, oERR, oBUSY, oI2C_CTRL_CLK, oI2C_GO, 20'd0} | (oI2C_DATA & 32'hFFFF_FFFF),
              32'd0);
        iRST = 1'b0;
    endtask

    task automatic wait_grant(input string name, output logic [3:0] g, output int cyc);
        g = '0;
        cyc = 0;
        for (int i = 1; i <= 3000; i++) begin
            step();
            if (oGRANT != 0) begin
                g = oGRANT;
                cyc = i;
                return;
            end
        end
        bound_fail(name);
    endtask

    task automatic wait_go(input string name, input logic level, output int cyc);
        cyc = 0;
        for (int i = 1; i <= 3000; i++) begin
            step();
            if (oI2C_GO === level) begin
                cyc = i;
                return;
            end
        end
        bound_fail(name);
    endtask

    task automatic wait_done(input string name, output logic [3:0] d, output logic e, output int cyc);
        d = '0;
        e = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 3000; i++) begin
            step();
            if (oDONE != 0) begin
                d = oDONE;
                e = oERR;
                cyc = i;
                return;
            end
        end
        bound_fail(name);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  exp_grant;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [3:0] g, d;
        logic       e;
        int         cyc, c1, c2, g0, d0;
        logic       cc_prev;

        vecs[0] = '{4'b1111, 4'b0001, D0};
        vecs[1] = '{4'b1111, 4'b0010, D1};
        vecs[2] = '{4'b1111, 4'b0100, D2};
        vecs[3] = '{4'b1111, 4'b1000, D3};
        vecs[4] = '{4'b1111, 4'b0001, D0};
        vecs[5] = '{4'b0100, 4'b0100, D2};
        vecs[6] = '{4'b1001, 4'b1000, D3};
        vecs[7] = '{4'b1010, 4'b0010, D1};
        vecs[8] = '{4'b0001, 4'b0001, D0};

        // Reset state and control-clock period.
        do_reset();
        c1 = 0;
        c2 = 0;
        cc_prev = oI2C_CTRL_CLK;
        for (int i = 1; i <= 60 && c2 == 0; i++) begin
            step();
            if (oI2C_CTRL_CLK !== cc_prev) begin
                if (c1 == 0) c1 = i;
                else c2 = i;
            end
            cc_prev = oI2C_CTRL_CLK;
        end
        check("ctrl_clk_first_toggle", 32'(c1), 32'd12);
        check("ctrl_clk_half_period", 32'(c2 - c1), 32'd12);

        // Single write.
        do_reset();
        iREQ = 4'b0001;
        wait_grant("single_grant_wait", g, cyc);
        check("single_grant", {28'd0, g}, 32'h1);
        check("single_grant_cycle", 32'(cyc), 32'd24);
        iREQ = '0;
        wait_go("single_go_wait", 1'b1, cyc);
        check("single_go_delay", 32'(cyc), 32'd24);
        check("single_data", oI2C_DATA, D0);
        check("single_slave", {24'd0, oI2C_DATA[SLAVE_LSB +: 8]}, {24'd0, CCD_SLAVE_ADDR});
        check("single_sub", {24'd0, oI2C_DATA[SUB_LSB +: 8]}, 32'h20);
        check("single_data16", {16'd0, oI2C_DATA[DATA_LSB +: 16]}, 32'hC000);
        check("single_busy", {31'd0, oBUSY}, 32'd1);
        wait_done("single_done_wait", d, e, cyc);
        check("single_done", {28'd0, d}, 32'h1);
        check("single_err", {31'd0, e}, 32'd0);
        check("single_busy_clear", {31'd0, oBUSY}, 32'd0);
        step();
        check("single_done_pulse", {28'd0, oDONE}, 32'd0);
        check("single_data_hold", oI2C_DATA, D0);

        // Round robin and pointer behaviour from a table.
        do_reset();
        foreach (vecs[i]) begin
            iREQ = vecs[i].req;
            wait_grant("rr_grant_wait", g, cyc);
            check($sformatf("rr_grant[%0d]", i), {28'd0, g}, {28'd0, vecs[i].exp_grant});
            wait_go("rr_go_wait", 1'b1, cyc);
            check($sformatf("rr_data[%0d]", i), oI2C_DATA, vecs[i].exp_data);
            wait_done("rr_done_wait", d, e, cyc);
            check($sformatf("rr_done[%0d]", i), {28'd0, d}, {28'd0, vecs[i].exp_grant});
            check($sformatf("rr_err[%0d]", i), {31'd0, e}, 32'd0);
        end
        iREQ = '0;

        // NACK on every attempt: three GO pulses then an error DONE.
        do_reset();
        m_nack = 1'b1;
        g0 = go_rises;
        iREQ = 4'b0100;
        wait_grant("nack_grant_wait", g, cyc);
        check("nack_grant", {28'd0, g}, 32'h4);
        iREQ = '0;
        wait_go("nack_go1_wait", 1'b1, cyc);
        wait_go("nack_go1_fall", 1'b0, cyc);
        wait_go("nack_go2_wait", 1'b1, cyc);
        check("nack_retry_gap", 32'(cyc), 32'd48);
        wait_done("nack_done_wait", d, e, cyc);
        check("nack_done", {28'd0, d}, 32'h4);
        check("nack_err", {31'd0, e}, 32'd1);
        check("nack_go_count", 32'(go_rises - g0), 32'd3);
        m_nack = 1'b0;

        // END never arrives: timeout after 5 ticks in WAIT_END.
        do_reset();
        m_never = 1'b1;
        iREQ = 4'b0001;
        wait_grant("to_grant_wait", g, cyc);
        iREQ = '0;
        wait_go("to_go_wait", 1'b1, cyc);
        wait_go("to_go_fall", 1'b0, cyc);
        check("to_go_width", 32'(cyc), 32'd120);
        wait_done("to_done_wait", d, e, cyc);
        check("to_done_delay", 32'(cyc), 32'd24);
        check("to_done", {28'd0, d}, 32'h1);
        check("to_err", {31'd0, e}, 32'd1);

        // Reset while requester 2 waits for END.
        do_reset();
        iREQ = 4'b0100;
        wait_grant("abort_grant_wait", g, cyc);
        check("abort_grant", {28'd0, g}, 32'h4);
        wait_go("abort_go_wait", 1'b1, cyc);
        repeat (30) step();
        d0 = done_pulses;
        iRST = 1'b1;
        step();
        check("abort_go_drop", {31'd0, oI2C_GO}, 32'd0);
        check("abort_busy_drop", {31'd0, oBUSY}, 32'd0);
        step();
        iRST = 1'b0;
        m_never = 1'b0;
        iREQ = 4'b1111;
        wait_grant("abort_regrant_wait", g, cyc);
        check("abort_regrant", {28'd0, g}, 32'h1);
        check("abort_no_done", 32'(done_pulses - d0), 32'd0);
        iREQ = '0;
        wait_done("abort_final_done_wait", d, e, cyc);
        check("abort_final_done", {28'd0, d}, 32'h1);

        check("go_outside_busy", 32'(viol), 32'd0);
        check("err_without_done", 32'(stray_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
